// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter
//   Arbitrates a MIPS core's instruction-fetch and data ports onto a single
//   Avalon-MM master. One transaction is in flight at a time:
//   IDLE -> BUS -> (RDATA ->) RESP -> IDLE. Every output is a register.
//
// Parameters
//   WAIT_LIMIT   consecutive waitrequest cycles tolerated per bus request
//                (2..255) before the transaction is aborted with bus_err.
//
// Optional feature
//   MEM_ARB_RR_EN  when defined, a tie between both requesters is granted to
//                  the one not granted last. When undefined, data wins ties.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   ifetch_req/addr             fetch request and address
//   ifetch_done/rdata           fetch completion pulse and fetched word
//   data_req/we/addr/wdata/be   data request (we=1 store, 0 load)
//   data_done/rdata             data completion pulse and load word
//   address/read/write/writedata/byteenable   Avalon master outputs
//   waitrequest, readdata       Avalon slave responses
//   busy                        high in any state other than IDLE
//   bus_err                     sticky timeout flag
//   stateDbg                    current FSM state (IDLE=0, BUS=1, RDATA=2, RESP=3)
//
// Handshake: a requester raises req with its fields stable and holds them
// until its done pulses (one cycle, rdata valid in that same cycle). req is
// only sampled in IDLE; a req still high in the done cycle is taken as a new
// request. On the bus side a command is accepted at the first edge where
// waitrequest=0; read data is expected the cycle after acceptance.
module mips_cpu_mem_arbiter #(
    parameter int WAIT_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_addr,
    output logic        ifetch_done,
    output logic [31:0] ifetch_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_be,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        bus_err,
    output logic [1:0]  stateDbg
);

    localparam logic [7:0] WaitLimit8 = WAIT_LIMIT[7:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state, stateNext;
    logic        grantData, grantDataNext;   // 1: data port owns the transaction
    logic        isWrite, isWriteNext;
    logic [7:0]  waitCnt, waitCntNext;
    logic [31:0] addressNext, writedataNext;
    logic [3:0]  byteenableNext;
    logic        readNext, writeNext;
    logic        ifetchDoneNext, dataDoneNext;
    logic [31:0] ifetchRdataNext, dataRdataNext;
    logic        busErrNext;
    logic        pickData;
    logic [7:0]  waitCntInc;
`ifdef MEM_ARB_RR_EN
    logic        lastData, lastDataNext;     // 1: data port was granted last
`endif

    assign stateDbg   = state;
    assign waitCntInc = waitCnt + 8'd1;

    // Winner if sampled now; only meaningful when at least one req is high.
`ifdef MEM_ARB_RR_EN
    assign pickData = data_req && (!ifetch_req || !lastData);
`else
    assign pickData = data_req;
`endif

    always_comb begin
        stateNext       = state;
        grantDataNext   = grantData;
        isWriteNext     = isWrite;
        waitCntNext     = waitCnt;
        addressNext     = address;
        readNext        = read;
        writeNext       = write;
        writedataNext   = writedata;
        byteenableNext  = byteenable;
        ifetchDoneNext  = 1'b0;
        dataDoneNext    = 1'b0;
        ifetchRdataNext = ifetch_rdata;
        dataRdataNext   = data_rdata;
        busErrNext      = bus_err;
`ifdef MEM_ARB_RR_EN
        lastDataNext    = lastData;
`endif

        unique case (state)
            IDLE: begin
                if (data_req || ifetch_req) begin
                    stateNext     = BUS;
                    grantDataNext = pickData;
                    waitCntNext   = 8'd0;
`ifdef MEM_ARB_RR_EN
                    lastDataNext  = pickData;
`endif
                    if (pickData) begin
                        addressNext    = {data_addr[31:2], 2'b00};
                        readNext       = !data_we;
                        writeNext      = data_we;
                        writedataNext  = data_wdata;
                        byteenableNext = data_be;
                        isWriteNext    = data_we;
                    end else begin
                        addressNext    = {ifetch_addr[31:2], 2'b00};
                        readNext       = 1'b1;
                        writeNext      = 1'b0;
                        writedataNext  = 32'h0;
                        byteenableNext = 4'b1111;
                        isWriteNext    = 1'b0;
                    end
                end
            end

            BUS: begin
                if (waitrequest) begin
                    waitCntNext = waitCntInc;
                    // Abort: drop the command and complete with zero data.
                    if (waitCntInc == WaitLimit8) begin
                        stateNext  = RESP;
                        readNext   = 1'b0;
                        writeNext  = 1'b0;
                        busErrNext = 1'b1;
                        if (grantData) dataRdataNext   = 32'h0;
                        else           ifetchRdataNext = 32'h0;
                    end
                end else begin
                    readNext  = 1'b0;
                    writeNext = 1'b0;
                    stateNext = isWrite ? RESP : RDATA;
                end
            end

            RDATA: begin
                if (grantData) dataRdataNext   = readdata;
                else           ifetchRdataNext = readdata;
                stateNext = RESP;
            end

            RESP: begin
                // done is registered here, so it is high in the following IDLE cycle.
                dataDoneNext   = grantData;
                ifetchDoneNext = !grantData;
                stateNext      = IDLE;
            end

            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grantData    <= 1'b0;
            isWrite      <= 1'b0;
            waitCnt      <= 8'd0;
            address      <= 32'h0;
            read         <= 1'b0;
            write        <= 1'b0;
            writedata    <= 32'h0;
            byteenable   <= 4'h0;
            ifetch_done  <= 1'b0;
            data_done    <= 1'b0;
            ifetch_rdata <= 32'h0;
            data_rdata   <= 32'h0;
            busy         <= 1'b0;
            bus_err      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            lastData     <= 1'b0;
`endif
        end else begin
            state        <= stateNext;
            grantData    <= grantDataNext;
            isWrite      <= isWriteNext;
            waitCnt      <= waitCntNext;
            address      <= addressNext;
            read         <= readNext;
            write        <= writeNext;
            writedata    <= writedataNext;
            byteenable   <= byteenableNext;
            ifetch_done  <= ifetchDoneNext;
            data_done    <= dataDoneNext;
            ifetch_rdata <= ifetchRdataNext;
            data_rdata   <= dataRdataNext;
            busy         <= (stateNext != IDLE);
            bus_err      <= busErrNext;
`ifdef MEM_ARB_RR_EN
            lastData     <= lastDataNext;
`endif
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
module tb_mips_cpu_mem_arbiter;

    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifetch_req, data_req, data_we, waitrequest;
    logic [31:0] ifetch_addr, data_addr, data_wdata, readdata;
    logic [3:0]  data_be;
    logic        ifetch_done, data_done, read, write, busy, bus_err;
    logic [31:0] ifetch_rdata, data_rdata, address, writedata;
    logic [3:0]  byteenable;
    logic [1:0]  stateDbg;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          mLastData = 1'b0;   // last grant went to data port
    bit          mErr      = 1'b0;
    logic [31:0] mFRd      = 32'h0;
    logic [31:0] mDRd      = 32'h0;

    typedef struct {
        bit          reqD;
        bit          reqF;
        bit          we;
        logic [31:0] fAddr;
        logic [31:0] dAddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rd;
        bit          expData;
        logic [31:0] expAddr;
        int          expBus;
        int          expLat;
        bit          expErr;
    } vec_t;

    vec_t tbl[6];

    mips_cpu_mem_arbiter #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
        .ifetch_done(ifetch_done), .ifetch_rdata(ifetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_be(data_be),
        .data_done(data_done), .data_rdata(data_rdata),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata),
        .busy(busy), .bus_err(bus_err), .stateDbg(stateDbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic bit model_pick(input bit rqD, input bit rqF);
`ifdef MEM_ARB_RR_EN
        return rqD && (!rqF || !mLastData);
`else
        return rqD && (rqF || !rqF);
`endif
    endfunction

    // Fill in the expected fields from the arbitration and latency rules.
    function automatic vec_t add_exp(input vec_t v);
        vec_t r = v;
        bit   isWr, tmo;
        r.expData = model_pick(v.reqD, v.reqF);
        r.expAddr = (r.expData ? v.dAddr : v.fAddr) & 32'hFFFF_FFFC;
        isWr      = r.expData && v.we;
        tmo       = (v.waits >= WL);
        r.expBus  = tmo ? WL : v.waits + 1;
        r.expLat  = tmo ? WL + 2 : (isWr ? 3 : 4) + v.waits;
        r.expErr  = mErr || tmo;
        return r;
    endfunction

    // Runs one arbitration: raise the requests, act as the Avalon slave,
    // drop every request when the winner's done arrives.
    task automatic txn(input vec_t v, input string tag);
        int          busN = 0;
        int          lat = -1;
        bit          acc = 1'b0;
        bit          loserDone = 1'b0;
        bit          fieldBad = 1'b0;
        bit          busyFirst = 1'b0;
        bit          busyAtDone = 1'b1;
        bit          isWr = v.expData && v.we;
        bit          tmo = (v.waits >= WL);
        logic [31:0] gotRd = 32'h0;
        logic [31:0] expRd;
        logic [3:0]  expBe = v.expData ? v.be : 4'b1111;

        expRd = tmo ? 32'h0 : (isWr ? mDRd : v.rd);
        @(negedge clk);
        ifetch_req  = v.reqF;  ifetch_addr = v.fAddr;
        data_req    = v.reqD;  data_we     = v.we;
        data_addr   = v.dAddr; data_wdata  = v.wdata; data_be = v.be;
        waitrequest = 1'b0;
        for (int c = 1; c <= 300 && lat < 0; c++) begin
            @(negedge clk);
            readdata = acc ? v.rd : $urandom();
            acc = 1'b0;
            if (c == 1) busyFirst = busy;
            if (read || write) begin
                busN++;
                if (address !== v.expAddr || byteenable !== expBe ||
                    read !== !isWr || write !== isWr ||
                    (isWr && writedata !== v.wdata))
                    fieldBad = 1'b1;
                waitrequest = (busN <= v.waits);
                acc = read && !waitrequest;
            end else begin
                waitrequest = 1'($urandom_range(0, 1));
            end
            if (v.expData ? ifetch_done : data_done) loserDone = 1'b1;
            if (v.expData ? data_done : ifetch_done) begin
                lat        = c;
                gotRd      = v.expData ? data_rdata : ifetch_rdata;
                busyAtDone = busy;
                ifetch_req = 1'b0;
                data_req   = 1'b0;
                waitrequest = 1'b0;
            end
        end
        check({tag, " latency"}, lat, v.expLat);
        check({tag, " bus_cycles"}, busN, v.expBus);
        check({tag, " bus_fields"}, 32'(fieldBad), 32'd0);
        check({tag, " loser_done"}, 32'(loserDone), 32'd0);
        check({tag, " busy"}, {busyFirst, busyAtDone}, 2'b10);
        check({tag, " rdata"}, gotRd, expRd);
        check({tag, " bus_err"}, 32'(bus_err), 32'(v.expErr));
        mLastData = v.expData;
        if (tmo) mErr = 1'b1;
        if (v.expData) mDRd = expRd; else mFRd = expRd;
        check({tag, " other_rdata"}, v.expData ? ifetch_rdata : data_rdata,
              v.expData ? mFRd : mDRd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mLastData = 1'b0; mErr = 1'b0; mFRd = 32'h0; mDRd = 32'h0;
    endtask

    initial begin
        vec_t v;
        bit   sawDone;

        reset = 1'b1;
        ifetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        ifetch_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; data_be = 4'h0;
        waitrequest = 1'b0; readdata = 32'h0;

        //            reqD reqF we  fAddr         dAddr         wdata         be       waits rd            expData expAddr       bus lat err
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'hBFC00000, 32'h0,        32'h0,        4'hF,    0, 32'h24020005, 1'b0, 32'hBFC00000, 1, 4, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'h00001003, 32'hDEADBEEF, 4'hF,    3, 32'h0,        1'b1, 32'h00001000, 4, 6, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0000200A, 32'h0,        4'b0011, 1, 32'h12345678, 1'b1, 32'h00002008, 2, 5, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h00400007, 32'h0,        32'h0,        4'h0,    2, 32'hCAFEF00D, 1'b0, 32'h00400004, 3, 6, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h00500000, 32'h00003000, 32'h0,        4'hF,    0, 32'h0000BEEF, 1'b1, 32'h00003000, 1, 4, 1'b0};
`ifdef MEM_ARB_RR_EN
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h00007008, 32'h00006004, 32'h0,        4'hF,    0, 32'h11112222, 1'b0, 32'h00007008, 1, 4, 1'b0};
`else
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h00007008, 32'h00006004, 32'h0,        4'hF,    0, 32'h11112222, 1'b1, 32'h00006004, 1, 4, 1'b0};
`endif

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset bus", {read, write, address, writedata, byteenable}, 0);
        check("reset status", {busy, bus_err, ifetch_done, data_done, stateDbg}, 0);
        check("reset rdata", ifetch_rdata | data_rdata, 32'h0);

        for (int i = 0; i < 6; i++) txn(tbl[i], $sformatf("tbl%0d", i));

        // Three back-to-back ties; the loser withdraws once the winner is done.
        for (int p = 0; p < 3; p++) begin
            v = '{1'b1, 1'b1, 1'b0, $urandom(), $urandom(), 32'h0, 4'hF, 0, $urandom(),
                  1'b0, 32'h0, 0, 0, 1'b0};
            txn(add_exp(v), $sformatf("pair%0d", p));
        end

        for (int r = 0; r < 20; r++) begin
            v.reqD  = 1'($urandom_range(0, 1));
            v.reqF  = v.reqD ? 1'($urandom_range(0, 1)) : 1'b1;
            v.we    = 1'($urandom_range(0, 1));
            v.fAddr = $urandom(); v.dAddr = $urandom(); v.wdata = $urandom();
            v.be    = 4'($urandom_range(0, 15));
            v.waits = $urandom_range(0, WL - 2);
            v.rd    = $urandom();
            txn(add_exp(v), $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a stalled read.
        @(negedge clk);
        ifetch_req = 1'b1; ifetch_addr = 32'h00100000; waitrequest = 1'b1;
        @(negedge clk);
        check("rstmid read_before", 32'(read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid after", {read, write, busy, ifetch_done, data_done}, 0);
        reset = 1'b0; ifetch_req = 1'b0; waitrequest = 1'b0;
        mLastData = 1'b0; mFRd = 32'h0; mDRd = 32'h0; mErr = 1'b0;
        sawDone = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ifetch_done || data_done) sawDone = 1'b1;
        end
        check("rstmid no_done", 32'(sawDone), 32'd0);
        txn(tbl[0], "rstmid next");

        // waitrequest stuck high: abort after WL cycles, sticky error.
        v = '{1'b0, 1'b1, 1'b0, 32'h00200010, 32'h0, 32'h0, 4'h0, 1000, 32'h55555555,
              1'b0, 32'h0, 0, 0, 1'b0};
        txn(add_exp(v), "timeout");
        v = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h00300020, 32'h0, 4'hF, 0, 32'h77778888,
              1'b0, 32'h0, 0, 0, 1'b0};
        txn(add_exp(v), "after_timeout");
        do_reset();
        check("err cleared", 32'(bus_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_mem_arbiter.md
MIPS_CPU_MEM_ARBITER -- requirements
Module: mips_cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 64, max consecutive waitrequest cycles tolerated per bus request (range 2..255).
REQ-002 SHALL have ports: one clock; reset is synchronous and active-high; clock port is named clk and reset port is named reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 ifetch_req  in  1  fetch request, held until ifetch_done; ifetch_addr  in  32  fetch address.
REQ-006 ifetch_done  out  1  one-cycle completion pulse; ifetch_rdata  out  32  fetched word, valid while ifetch_done=1.
REQ-007 data_req  in  1  data request, held until data_done; data_we  in  1  1=store, 0=load; data_addr  in  32; data_wdata  in  32; data_be  in  4.
REQ-008 data_done  out  1  one-cycle completion pulse; data_rdata  out  32  load word, valid while data_done=1.
REQ-009 address  out  32; read  out  1; write  out  1; writedata  out  32; byteenable  out  4: Avalon master outputs.
REQ-010 waitrequest  in  1  stall; readdata  in  32  valid the cycle after an accepted read.
REQ-011 busy  out  1  high in any non-IDLE state; bus_err  out  1  sticky timeout flag.

Function
REQ-012 SHALL implement FSM IDLE -> BUS -> (RDATA ->) RESP -> IDLE; all outputs registered.
REQ-013 IDLE: at an edge with any req high, SHALL grant one requester, latch its address/data/be/we, enter BUS; no req -> stay IDLE.
REQ-014 Default arbitration: data_req wins over ifetch_req when both are high at the same edge.
REQ-015 BUS: address = latched address with bits[1:0] forced to 0; fetch drives read=1, byteenable=4'b1111; data drives read=!we, write=we, byteenable=data_be, writedata=data_wdata.
REQ-016 BUS: read/write and address/writedata/byteenable SHALL stay constant while waitrequest=1.
REQ-017 BUS, waitrequest=0 at edge: read -> RDATA; write -> RESP.
REQ-018 RDATA: SHALL deassert read and capture readdata into the granted requester's rdata register at the end of the cycle, then enter RESP.
REQ-019 RESP: SHALL assert the granted requester's done for exactly one cycle; ungranted done SHALL stay 0; then return to IDLE.
REQ-020 req inputs SHALL NOT be sampled in BUS/RDATA/RESP; a req still high in the first IDLE cycle after RESP starts a new transaction.
REQ-021 Zero-wait latency from the granting edge: write done in cycle 3, read done in cycle 4; each waitrequest cycle adds one.
REQ-022 Wait counter (8 bits) SHALL clear on entering BUS and increment on each waitrequest=1 cycle in BUS.
REQ-023 Counter reaching WAIT_LIMIT: SHALL deassert read/write, set bus_err=1, pulse the granted done with rdata=32'h00000000, return to IDLE via RESP.
REQ-024 rdata registers SHALL hold their value between transactions.

Reset
REQ-025 reset=1 at an edge: state=IDLE; read=0, write=0, address=0, writedata=0, byteenable=0, both done=0, both rdata=0, busy=0, bus_err=0, wait counter=0, round-robin pointer=fetch-last.
REQ-026 reset during BUS/RDATA/RESP SHALL abandon the transaction with no done pulse; bus signals are low the cycle after the reset edge.

Configuration
REQ-027 Macro MEM_ARB_RR_EN: when defined, a tie (both req high) SHALL grant the requester not granted last; the pointer updates on each grant. When undefined, fixed priority REQ-014 applies and no pointer exists.

Verification
REQ-028 Fetch only, ifetch_addr=32'hBFC00000, waitrequest=0, readdata=32'h24020005 -> address=32'hBFC00000, read=1 for 1 cycle, ifetch_done in cycle 4 with ifetch_rdata=32'h24020005.
REQ-029 Store data_addr=32'h00001003, wdata=32'hDEADBEEF, be=4'b1111, waitrequest=1 for 3 cycles -> address=32'h00001000, write held 4 cycles, data_done in cycle 6.
REQ-030 Both req high at the same edge, 3 back-to-back pairs -> without macro: data,data,data first; with MEM_ARB_RR_EN: alternate data,fetch,data.
REQ-031 waitrequest stuck high, WAIT_LIMIT=4 -> read drops after 4 wait cycles, bus_err=1 and stays 1, done pulses with rdata=0.
REQ-032 reset asserted in BUS cycle with waitrequest=1 -> read=0 next cycle, no done pulse, busy=0; next request completes normally.
